// File: rtl/gmii_tx_mac_if.sv
// Stream-in / GMII-out signal bundle for gmii_tx_mac.
//   master : payload source side (drives s_data/s_valid/s_last, observes the rest)
//   slave  : the MAC itself (consumes the stream, drives GMII and status)
// Signals:
//   s_data[7:0], s_valid, s_last  payload byte stream into the MAC
//   s_ready                       MAC accepts s_data this cycle
//   tx_en_, txd_[7:0]             GMII transmit enable / data towards the PCS
//   frame_done, abort             one-cycle completion / abort pulses
//   busy                          MAC is not idle
interface gmii_tx_mac_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       tx_en_;
  logic [7:0] txd_;
  logic       frame_done;
  logic       abort;
  logic       busy;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, tx_en_, txd_, frame_done, abort, busy
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, tx_en_, txd_, frame_done, abort, busy
  );
endinterface

// File: rtl/gmii_tx_mac.sv
// MAC-side GMII transmit framer. Takes payload bytes over a valid/ready stream and emits
// preamble, SFD, payload, pad to MIN_LEN, then an inter-packet gap. Source underrun or a
// payload reaching MAX_LEN without s_last drops tx_en_ at once, pulses abort and drains the
// rest of the frame from the source.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gmii_tx_mac_if.slave: stream input, GMII output, frame_done/abort/busy status
module gmii_tx_mac #(
  parameter int unsigned PRE_LEN  = 7,
  parameter int unsigned MIN_LEN  = 60,
  parameter int unsigned MAX_LEN  = 1514,  // must be <= 65535
  parameter int unsigned IPG_LEN  = 12,    // must be >= 2
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input logic           clk,
  input logic           rst_n,
  gmii_tx_mac_if.slave  bus
);

  localparam int unsigned PhMax = (PRE_LEN > IPG_LEN) ? PRE_LEN : IPG_LEN;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  localparam logic [PhW-1:0] PhOne   = PhW'(1);
  localparam logic [PhW-1:0] PreLast = PhW'(PRE_LEN);
  // The IDLE cycle after IPG is itself the final gap cycle, so IPG occupies IPG_LEN-1
  // cycles and a pending frame starts exactly IPG_LEN cycles after tx_en_ falls.
  localparam logic [PhW-1:0] IpgLast = PhW'(IPG_LEN - 1);
  localparam logic [15:0]    MinLen  = 16'(MIN_LEN);
  localparam logic [15:0]    MaxLen  = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StData,
    StPad,
    StEnd,
    StDrain,
    StIpg
  } state_e;

  state_e         state_q, state_d;
  logic [PhW-1:0] ph_q, ph_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           tx_en_q, tx_en_d;
  logic [7:0]     txd_q, txd_d;
  logic           done_q, done_d;
  logic           abort_q, abort_d;

  logic        s_ready;
  logic        xfer;
  logic [15:0] cnt_inc;

  assign s_ready = (state_q == StData) || (state_q == StDrain);
  assign xfer    = bus.s_valid && s_ready;
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    tx_en_d = tx_en_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        // s_valid only triggers the preamble; the byte waits for the SFD cycle.
        if (bus.s_valid) begin
          tx_en_d = 1'b1;
          txd_d   = 8'h55;
          ph_d    = PhOne;
          state_d = StPre;
        end
      end

      StPre: begin
        if (ph_q == PreLast) begin
          txd_d   = 8'hD5;
          cnt_d   = '0;
          state_d = StData;
        end else begin
          txd_d = 8'h55;
          ph_d  = ph_q + PhOne;
        end
      end

      StData: begin
        if (!bus.s_valid) begin
          // Underrun: end the burst now rather than emit a gap inside the frame.
          tx_en_d = 1'b0;
          txd_d   = 8'h00;
          abort_d = 1'b1;
          state_d = StDrain;
        end else if (cnt_inc == MaxLen && !bus.s_last) begin
          // Oversize: the byte taken on this edge is never put on the wire. s_last is
          // low here, so the remainder of the frame always has to be drained.
          tx_en_d = 1'b0;
          txd_d   = 8'h00;
          abort_d = 1'b1;
          state_d = StDrain;
        end else begin
          txd_d = bus.s_data;
          cnt_d = cnt_inc;
          if (bus.s_last) begin
            state_d = (cnt_inc < MinLen) ? StPad : StEnd;
          end
        end
      end

      StPad: begin
        txd_d = PAD_BYTE;
        cnt_d = cnt_inc;
        if (cnt_inc >= MinLen) begin
          state_d = StEnd;
        end
      end

      StEnd: begin
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        done_d  = 1'b1;
        ph_d    = PhOne;
        state_d = StIpg;
      end

      StDrain: begin
        if (xfer && bus.s_last) begin
          ph_d    = PhOne;
          state_d = StIpg;
        end
      end

      StIpg: begin
        if (ph_q >= IpgLast) begin
          state_d = StIdle;
        end else begin
          ph_d = ph_q + PhOne;
        end
      end

      default: begin
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ph_q    <= '0;
      cnt_q   <= '0;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.tx_en_     = tx_en_q;
  assign bus.txd_       = txd_q;
  assign bus.frame_done = done_q;
  assign bus.abort      = abort_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed bench for gmii_tx_mac: a table of frame scenarios (length, frame count,
// underrun point) with hand-computed burst lengths, pulse counts and gap lengths, plus
// hand-written reset-state and mid-frame reset sequences.
module tb_gmii_tx_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  gmii_tx_mac_if bus ();

  gmii_tx_mac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int len;        // payload bytes per frame
    int nfr;        // back-to-back frames
    int drop_at;    // payload index where s_valid drops for one cycle, -1 for none
    int exp_burst;  // tx_en_ cycles per burst
    int exp_done;   // frame_done high cycles
    int exp_abort;  // abort high cycles
    int exp_gap;    // tx_en_=0 cycles between bursts, -1 when single frame
    int exp_tail;   // tx_en_=0 cycles after last burst up to and including first busy=0
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int pos, input int len);
    if (pos < 7) return 8'h55;
    if (pos == 7) return 8'hD5;
    if (pos - 8 < len) return 8'((pos - 8) & 255);
    return 8'h00;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  total, idx, nb, pos, zr, gap, tail, dcnt, acnt, ovl, derr, bad_pos;
    int  blen [2];
    bit  dropped, prev_en, seen_busy, done;
    total = v.len * v.nfr;
    idx = 0; nb = 0; pos = 0; zr = 0; gap = -1; tail = -1;
    dcnt = 0; acnt = 0; ovl = 0; derr = 0; bad_pos = -1;
    blen[0] = 0; blen[1] = 0;
    dropped = 0; prev_en = 0; seen_busy = 0; done = 0;
    for (int c = 0; c < total + 400 && !done; c++) begin
      @(negedge clk);
      // Observe what the last rising edge produced.
      if (bus.tx_en_) begin
        if (!prev_en) begin
          if (nb == 1) gap = zr;
          nb++;
          pos = 0;
          zr  = 0;
        end
        if (bus.txd_ !== exp_byte(pos, v.len)) begin
          derr++;
          if (bad_pos < 0) bad_pos = pos;
        end
        pos++;
        if (nb <= 2) blen[nb-1] = pos;
      end else if (nb > 0) begin
        zr++;
      end
      prev_en = bus.tx_en_;
      if (bus.frame_done) dcnt++;
      if (bus.abort) acnt++;
      if (bus.frame_done && bus.abort) ovl++;
      if (bus.busy) seen_busy = 1;
      if (seen_busy && !bus.busy && idx == total) begin
        tail = zr;
        done = 1;
      end
      // Drive the next edge; s_ready is stable until that edge.
      if (!done) begin
        if (idx < total) begin
          if ((idx % v.len) == v.drop_at && !dropped && bus.s_ready) begin
            bus.s_valid = 1'b0;
            dropped = 1;
          end else begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'((idx % v.len) & 255);
            bus.s_last  = ((idx % v.len) == v.len - 1);
            if (bus.s_ready) idx++;
          end
        end else begin
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    check({tag, " finished"}, int'(done), 1);
    check({tag, " bursts"}, nb, v.nfr);
    check({tag, " burst_len"}, blen[0], v.exp_burst);
    if (v.nfr == 2) check({tag, " burst2_len"}, blen[1], v.exp_burst);
    if (derr != 0) $display("  %s first bad txd_ at burst position %0d", tag, bad_pos);
    check({tag, " txd_errors"}, derr, 0);
    check({tag, " frame_done"}, dcnt, v.exp_done);
    check({tag, " abort"}, acnt, v.exp_abort);
    check({tag, " done_abort_overlap"}, ovl, 0);
    if (v.exp_gap >= 0) check({tag, " interframe_gap"}, gap, v.exp_gap);
    check({tag, " tail_idle"}, tail, v.exp_tail);
    check({tag, " bytes_accepted"}, idx, total);
  endtask

  vec_t vecs [9];

  initial begin
    int idx;
    vecs[0] = '{64,   1, -1, 72,   1, 0, -1, 12};  // 0x00..0x3F, no pad
    vecs[1] = '{10,   1, -1, 68,   1, 0, -1, 12};  // 10 payload + 50 pad
    vecs[2] = '{100,  1, 20, 28,   0, 1, -1, 92};  // underrun after 20 bytes, 80 drained
    vecs[3] = '{1600, 1, -1, 1521, 0, 1, -1, 98};  // oversize at byte 1514, 86 drained
    vecs[4] = '{60,   2, -1, 68,   2, 0, 12, 12};  // back-to-back minimum frames
    vecs[5] = '{59,   1, -1, 68,   1, 0, -1, 12};  // single pad byte
    vecs[6] = '{61,   1, -1, 69,   1, 0, -1, 12};  // just over minimum
    vecs[7] = '{1,    1, -1, 68,   1, 0, -1, 12};  // one byte, 59 pad
    vecs[8] = '{1514, 1, -1, 1522, 1, 0, -1, 12};  // exactly MAX_LEN with s_last

    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    // Reset state.
    #1;
    check("reset tx_en_", int'(bus.tx_en_), 0);
    check("reset txd_", int'(bus.txd_), 0);
    check("reset s_ready", int'(bus.s_ready), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    check("reset abort", int'(bus.abort), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while payload byte 30 is being driven onto the wire.
    idx = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (idx == 30) break;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(idx);
      bus.s_last  = 1'b0;
      if (bus.s_ready) idx++;
    end
    check("midreset tx_en_ before", int'(bus.tx_en_), 1);
    check("midreset txd_ before", int'(bus.txd_), 29);
    #2 rst_n = 1'b0;
    #1;
    check("midreset tx_en_", int'(bus.tx_en_), 0);
    check("midreset txd_", int'(bus.txd_), 0);
    check("midreset s_ready", int'(bus.s_ready), 0);
    check("midreset busy", int'(bus.busy), 0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
